// File: rtl/dmem_ctrl_pkg.sv
// Shared types and widths for the data-memory access sequencer.
package dmem_ctrl_pkg;

  localparam int DADDR_W = 8;
  localparam int RADDR_W = 5;

  typedef enum logic [2:0] {
    IDLE,
    ST_WR,
    LD_ADDR,
    LD_WAIT,
    LD_WB
  } state_e;

  typedef enum logic {
    OP_LOAD  = 1'b0,
    OP_STORE = 1'b1
  } op_e;

endpackage

// File: rtl/dmem_ctrl_perf.sv
// Saturating load/store event counters; each increments by one in the cycle after its strobe.
// Never stalls the sequencer; counts stick at 16'hFFFF.
module dmem_ctrl_perf (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_ld_inc,
  input  logic        i_st_inc,
  output logic [15:0] o_ld_count,
  output logic [15:0] o_st_count
);

  logic [15:0] r_ld_cnt;
  logic [15:0] r_st_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ld_cnt <= 16'd0;
      r_st_cnt <= 16'd0;
    end else begin
      if (i_ld_inc && (r_ld_cnt != 16'hFFFF)) r_ld_cnt <= r_ld_cnt + 16'd1;
      if (i_st_inc && (r_st_cnt != 16'hFFFF)) r_st_cnt <= r_st_cnt + 16'd1;
    end
  end

  assign o_ld_count = r_ld_cnt;
  assign o_st_count = r_st_cnt;

endmodule

// File: rtl/dmem_access_ctrl.sv
// Load/store strobe sequencer: store busy 1 cycle, load busy DMEM_RD_LAT+1; cmd_ready only in IDLE, no queuing.
// DMEM_ACCESS_CTRL_PERF_EN adds saturating ld_count/st_count outputs.
module dmem_access_ctrl
  import dmem_ctrl_pkg::*;
#(
  parameter int DMEM_RD_LAT = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic               cmd_op,
  input  logic [DADDR_W-1:0] cmd_addr,
  input  logic [RADDR_W-1:0] cmd_reg,
  output logic [DADDR_W-1:0] D_addr,
  output logic               Dmem_write,
  output logic               Reg_write,
  output logic [RADDR_W-1:0] Reg_w_addr,
  output logic [RADDR_W-1:0] Reg_Ra_addr,
  output logic               done,
  output logic               busy
`ifdef DMEM_ACCESS_CTRL_PERF_EN
  ,
  output logic [15:0]        ld_count,
  output logic [15:0]        st_count
`endif
);

  localparam logic [1:0] WAIT_INIT = 2'((DMEM_RD_LAT > 1) ? (DMEM_RD_LAT - 2) : 0);

  state_e             r_state;
  state_e             w_next;
  logic [DADDR_W-1:0] r_addr;
  logic [RADDR_W-1:0] r_reg;
  logic [1:0]         r_wait;
  logic               w_accept;

  assign w_accept = cmd_valid && (r_state == IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr <= '0;
      r_reg  <= '0;
    end else if (w_accept) begin
      r_addr <= cmd_addr;
      r_reg  <= cmd_reg;
    end
  end

  // Loaded while leaving LD_ADDR so LD_WAIT spans exactly DMEM_RD_LAT-1 cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                 r_wait <= 2'd0;
    else if (r_state == LD_ADDR)                r_wait <= WAIT_INIT;
    else if (r_state == LD_WAIT && r_wait != 0) r_wait <= r_wait - 2'd1;
  end

  always_comb begin
    w_next     = r_state;
    cmd_ready  = 1'b0;
    Dmem_write = 1'b0;
    Reg_write  = 1'b0;
    done       = 1'b0;
    case (r_state)
      IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) w_next = (cmd_op == OP_STORE) ? ST_WR : LD_ADDR;
      end
      ST_WR: begin
        Dmem_write = 1'b1;
        done       = 1'b1;
        w_next     = IDLE;
      end
      LD_ADDR: w_next = (DMEM_RD_LAT > 1) ? LD_WAIT : LD_WB;
      LD_WAIT: if (r_wait == 2'd0) w_next = LD_WB;
      LD_WB: begin
        Reg_write = 1'b1;
        done      = 1'b1;
        w_next    = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  assign busy        = (r_state != IDLE);
  assign D_addr      = r_addr;
  assign Reg_w_addr  = r_reg;
  assign Reg_Ra_addr = r_reg;

`ifdef DMEM_ACCESS_CTRL_PERF_EN
  dmem_ctrl_perf u_perf (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_ld_inc   (r_state == LD_WB),
    .i_st_inc   (r_state == ST_WR),
    .o_ld_count (ld_count),
    .o_st_count (st_count)
  );
`endif

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Bench for dmem_access_ctrl: read latency 1 and 3 instances share stimulus; a transaction-level model predicts outputs.
module tb_dmem_access_ctrl;

  logic       clk       = 1'b0;
  logic       rst_n     = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_op    = 1'b0;
  logic [7:0] cmd_addr  = 8'd0;
  logic [4:0] cmd_reg   = 5'd0;

  logic [1:0] rdy, bsy, dwr, rwr, dn;
  logic [7:0] daddr [2];
  logic [4:0] wad   [2];
  logic [4:0] rad   [2];
`ifdef DMEM_ACCESS_CTRL_PERF_EN
  logic [15:0] ldc [2];
  logic [15:0] stc [2];
`endif

  int total = 0;
  int bad   = 0;

  // Model: busy cycles left per instance, plus the last accepted command.
  int         lat [2] = '{1, 3};
  int         rem [2];
  bit         isst [2];
  logic [7:0] m_addr [2];
  logic [4:0] m_reg  [2];
  int         exp_done [2];
  int         obs_done [2];
  int         m_ld [2];
  int         m_st [2];

  always #5 clk = ~clk;

  dmem_access_ctrl #(.DMEM_RD_LAT(1)) u_lat1 (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(rdy[0]),
    .cmd_op(cmd_op), .cmd_addr(cmd_addr), .cmd_reg(cmd_reg),
    .D_addr(daddr[0]), .Dmem_write(dwr[0]), .Reg_write(rwr[0]),
    .Reg_w_addr(wad[0]), .Reg_Ra_addr(rad[0]), .done(dn[0]), .busy(bsy[0])
`ifdef DMEM_ACCESS_CTRL_PERF_EN
    , .ld_count(ldc[0]), .st_count(stc[0])
`endif
  );

  dmem_access_ctrl #(.DMEM_RD_LAT(3)) u_lat3 (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(rdy[1]),
    .cmd_op(cmd_op), .cmd_addr(cmd_addr), .cmd_reg(cmd_reg),
    .D_addr(daddr[1]), .Dmem_write(dwr[1]), .Reg_write(rwr[1]),
    .Reg_w_addr(wad[1]), .Reg_Ra_addr(rad[1]), .done(dn[1]), .busy(bsy[1])
`ifdef DMEM_ACCESS_CTRL_PERF_EN
    , .ld_count(ldc[1]), .st_count(stc[1])
`endif
  );

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] want);
    total++;
    if (obs !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", tag, obs, want, $time);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      rem[d]    = 0;
      isst[d]   = 1'b0;
      m_addr[d] = 8'd0;
      m_reg[d]  = 5'd0;
      m_ld[d]   = 0;
      m_st[d]   = 0;
    end
  endtask

  // A store occupies 1 busy cycle, a load lat+1; accept only when nothing is left.
  task automatic model_step(input int d);
    if (rem[d] > 0) begin
      rem[d]--;
    end else if (cmd_valid) begin
      isst[d]   = cmd_op;
      rem[d]    = cmd_op ? 1 : lat[d] + 1;
      m_addr[d] = cmd_addr;
      m_reg[d]  = cmd_reg;
    end
  endtask

  task automatic check_dut(input int d);
    logic [4:0] e;
    bit         last;
    string      p;
    last = (rem[d] == 1);
    p    = $sformatf("lat%0d", lat[d]);
    e    = {rem[d] == 0, rem[d] != 0, last && isst[d], last && !isst[d], last};
    check_val({p, ".rdy_bsy_dwr_rwr_done"}, {27'd0, rdy[d], bsy[d], dwr[d], rwr[d], dn[d]}, {27'd0, e});
    check_val({p, ".D_addr"},      {24'd0, daddr[d]}, {24'd0, m_addr[d]});
    check_val({p, ".Reg_w_addr"},  {27'd0, wad[d]},   {27'd0, m_reg[d]});
    check_val({p, ".Reg_Ra_addr"}, {27'd0, rad[d]},   {27'd0, m_reg[d]});
`ifdef DMEM_ACCESS_CTRL_PERF_EN
    check_val({p, ".ld_count"}, {16'd0, ldc[d]}, 32'(m_ld[d]));
    check_val({p, ".st_count"}, {16'd0, stc[d]}, 32'(m_st[d]));
`endif
    if (last) exp_done[d]++;
    if (last && isst[d])  m_st[d]++;
    if (last && !isst[d]) m_ld[d]++;
    obs_done[d] += int'(dn[d]);
  endtask

  task automatic cycle();
    @(posedge clk);
    if (rst_n) begin
      model_step(0);
      model_step(1);
    end
    #1;
    check_dut(0);
    check_dut(1);
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while ((rem[0] != 0 || rem[1] != 0) && n < 20) begin
      cycle();
      n++;
    end
    check_val(tag, {30'd0, rdy}, 32'd3);
  endtask

  task automatic send(input logic op, input logic [7:0] a, input logic [4:0] r);
    wait_idle("send.ready");
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_addr  = a;
    cmd_reg   = r;
    cycle();
    cmd_valid = 1'b0;
  endtask

  initial begin
    model_reset();
    for (int d = 0; d < 2; d++) begin
      exp_done[d] = 0;
      obs_done[d] = 0;
    end

    repeat (3) cycle();
    rst_n = 1'b1;
    repeat (3) cycle();

    send(1'b1, 8'h01, 5'h03);
    repeat (3) cycle();
    send(1'b0, 8'h01, 5'h04);
    repeat (5) cycle();
    send(1'b0, 8'hFF, 5'h1F);
    repeat (6) cycle();

    // Valid held high: one command per completion, fields ignored while busy.
    cmd_valid = 1'b1;
    for (int i = 0; i < 40; i++) begin
      cmd_op   = ~cmd_op;
      cmd_addr = 8'($urandom);
      cmd_reg  = 5'($urandom);
      cycle();
    end
    cmd_valid = 1'b0;

    for (int i = 0; i < 400; i++) begin
      cmd_valid = 1'($urandom_range(0, 1));
      cmd_op    = 1'($urandom_range(0, 1));
      cmd_addr  = 8'($urandom);
      cmd_reg   = 5'($urandom);
      cycle();
    end
    cmd_valid = 1'b0;
    wait_idle("drain.ready");

    for (int d = 0; d < 2; d++)
      check_val($sformatf("lat%0d.done_total", lat[d]), 32'(obs_done[d]), 32'(exp_done[d]));

    // Reset while the latency-3 instance sits in LD_WAIT; outputs must drop with no clock edge.
    send(1'b0, 8'h5A, 5'h00);
    cycle();
    check_val("lat3.in_ld_wait", {31'd0, bsy[1]}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_dut(0);
    check_dut(1);
    repeat (4) cycle();
    rst_n = 1'b1;
    repeat (4) cycle();

    send(1'b1, 8'hA5, 5'h11);
    wait_idle("final.ready");
    repeat (2) cycle();

    for (int d = 0; d < 2; d++)
      check_val($sformatf("lat%0d.done_final", lat[d]), 32'(obs_done[d]), 32'(exp_done[d]));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
